// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter slice.
//   BUS_ARB_ID_W(n) : width of a master index for n masters (at least 1 bit)
//   BUS_ERR_DATA    : read data returned to a master whose request timed out
//   MASTER_*        : conventional master slots (instruction fetch, data memory, debug)
//   arb_state_t     : arbiter grant state (free to re-arbitrate, or holding a grant)

`ifndef BUS_ARB_ID_W
`define BUS_ARB_ID_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package bus_rr_arbiter_pkg;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int MASTER_IF   = 0;
  localparam int MASTER_MEM  = 1;
  localparam int MASTER_JTAG = 2;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Synchronous FIFO holding the master id of every accepted, unanswered request,
// so in-order responses can be steered back to their issuer.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   dout       : current head entry
//   full/empty : occupancy flags
//   count      : number of stored entries

module bus_arb_id_fifo
  import bus_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps the pointers correct for any depth, including 1.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one slave req/addr_ok/data_ok port among NUM_MASTERS
// masters, with zero added latency on the request and response paths.
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable a response watchdog that
// answers a stalled head request with BUS_ERR_DATA and a one-cycle bus_err pulse.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   m_req/m_we           : per-master request and write enable
//   m_addr/m_wdata/m_wem : flattened per-master address, write data, byte mask
//   m_addr_ok/m_data_ok  : one-hot (or zero) accept and response strobes
//   m_rdata              : broadcast read data
//   s_req..s_wem         : request towards the slave, muxed from the granted master
//   s_addr_ok/s_data_ok  : slave accept / in-order response
//   s_rdata              : slave read data
//   outst_cnt            : accepted, unanswered requests
//   bus_err              : watchdog timeout pulse (0 without BUS_ARB_TIMEOUT_EN)

module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = 4,
  parameter int MAX_OUTST   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic [NUM_MASTERS-1:0]         m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]  m_wdata,
  input  logic [NUM_MASTERS*MASK_W-1:0]  m_wem,
  output logic [NUM_MASTERS-1:0]         m_addr_ok,
  output logic [NUM_MASTERS-1:0]         m_data_ok,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           s_req,
  output logic                           s_we,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [MASK_W-1:0]              s_wem,
  input  logic                           s_addr_ok,
  input  logic                           s_data_ok,
  input  logic [DATA_W-1:0]              s_rdata,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           bus_err
);

  localparam int ID_W = `BUS_ARB_ID_W(NUM_MASTERS);

  arb_state_t      state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] lock_id;
  logic [ID_W-1:0] rr_id;
  logic            rr_valid;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;
  logic [ID_W-1:0] head_id;
  logic            fifo_full;
  logic            fifo_empty;
  logic            handshake;
  logic            resp_valid;
  logic            timeout_hit;
  logic            pop;

  // Scanning downwards and overwriting leaves the first requester after rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    rr_id    = '0;
    rr_valid = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_MASTERS;
      if (m_req[ID_W'(idx)]) begin
        rr_id    = ID_W'(idx);
        rr_valid = 1'b1;
      end
    end
  end

  // A stalled request keeps its grant; other masters cannot pre-empt it.
  always_comb begin
    gnt_id    = rr_id;
    gnt_valid = rr_valid;
    if (state == ARB_LOCKED) begin
      gnt_id    = lock_id;
      gnt_valid = m_req[lock_id];
    end
  end

  // Full is decided from registered occupancy only, so data_ok never reaches s_req.
  assign s_req     = rst_n & gnt_valid & ~fifo_full;
  assign handshake = s_req & s_addr_ok;
  assign m_addr_ok = handshake ? (NUM_MASTERS'(1) << gnt_id) : '0;

  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wem   = '0;
    if (s_req) begin
      s_we    = m_we[gnt_id];
      s_addr  = m_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(gnt_id)*DATA_W +: DATA_W];
      s_wem   = m_wem[int'(gnt_id)*MASK_W +: MASK_W];
    end
  end

  // A response with nothing outstanding is dropped instead of being routed.
  assign resp_valid = s_data_ok & ~fifo_empty;
  assign pop        = resp_valid | timeout_hit;
  assign m_data_ok  = pop ? (NUM_MASTERS'(1) << head_id) : '0;
  assign m_rdata    = timeout_hit ? DATA_W'(BUS_ERR_DATA) : (resp_valid ? s_rdata : '0);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires during the TIMEOUT_CYC-th consecutive cycle spent waiting on the head.
  assign timeout_hit = ~fifo_empty & ~s_data_ok & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign bus_err     = timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (fifo_empty || s_data_ok || timeout_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign bus_err            = 1'b0;
`endif

  bus_arb_id_fifo #(
    .DEPTH(MAX_OUTST),
    .W    (ID_W)
  ) u_id_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (handshake),
    .pop  (pop),
    .din  (gnt_id),
    .dout (head_id),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(outst_cnt)
  );

  // rr_ptr starts at the last master so master 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_OPEN;
      lock_id <= '0;
      rr_ptr  <= ID_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_next;
      if (s_req && !s_addr_ok) lock_id <= gnt_id;
      if (handshake)           rr_ptr  <= gnt_id;
    end
  end

  // A held master that withdraws releases the lock so arbitration resumes.
  always_comb begin
    state_next = state;
    case (state)
      ARB_OPEN:   if (s_req && !s_addr_ok) state_next = ARB_LOCKED;
      ARB_LOCKED: if (handshake || !m_req[lock_id]) state_next = ARB_OPEN;
      default:    state_next = ARB_OPEN;
    endcase
  end

  hold_req_while_locked: assert property (
    @(posedge clk) disable iff (!rst_n) (state == ARB_LOCKED) |-> m_req[lock_id]);

endmodule
